// File: rtl/dds_pkg.sv
// Shared definitions for the dds block and its configuration loader.
package dds_pkg;

  localparam int DDS_SIG_WIDTH = 16;
  localparam int DDS_ADDR_W    = 9;
  localparam logic [DDS_ADDR_W-1:0] DDS_IDLE_ADDR = 9'h1FF;

  // FIFO select codes on the dds address port
  localparam logic [1:0] THETAS = 2'd0;
  localparam logic [1:0] DELTAS = 2'd1;
  localparam logic [1:0] AMPLS  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD_TH = 3'd2,
    ST_LOAD_DE = 3'd3,
    ST_LOAD_AM = 3'd4,
    ST_RUN     = 3'd5
  } dds_ld_state_t;

  // FIFO code targeted by a loading state
  function automatic logic [1:0] field_of(dds_ld_state_t s);
    case (s)
      ST_LOAD_DE: field_of = DELTAS;
      ST_LOAD_AM: field_of = AMPLS;
      default:    field_of = THETAS;
    endcase
  endfunction

endpackage

// File: rtl/dds_loader.sv
// Streams one frame of channel parameters (thetas, deltas, amplitudes) into the
// dds circulating FIFOs, then holds the dds in run mode.
module dds_loader
  import dds_pkg::*;
#(
  parameter int SIG_WIDTH = DDS_SIG_WIDTH,
  parameter int N_CH      = 8,
  parameter int ADDR_W    = DDS_ADDR_W,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(DDS_IDLE_ADDR)
) (
  input  logic                 clk,
  input  logic                 a_rst_n,
  input  logic                 i_load_req,
  input  logic                 i_stop,
  input  logic [SIG_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic                 o_dds_rst,
  output logic                 o_dds_start,
  output logic [ADDR_W-1:0]    o_dds_addrs,
  output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
  output logic                 o_busy,
  output logic                 o_running,
  output logic                 o_err
);

  localparam int CNT_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CH - 1);

  dds_ld_state_t        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rst_q, rst_d;
  logic                 start_q, start_d;
  logic [ADDR_W-1:0]    addrs_q, addrs_d;
  logic [SIG_WIDTH-1:0] data_q, data_d;
  logic                 err_q, err_d;

  logic loading, hs, final_word;

  assign loading    = (state_q == ST_LOAD_TH) || (state_q == ST_LOAD_DE) ||
                      (state_q == ST_LOAD_AM);
  assign hs         = s_axis_tvalid && loading;
  assign final_word = (state_q == ST_LOAD_AM) && (cnt_q == CNT_LAST);

  // Next-state and next-output logic; dds outputs default to "no write, no reset"
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = 1'b0;
    start_d = 1'b0;
    addrs_d = IDLE_ADDR;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_load_req) begin
          state_d = ST_CLEAR;
          err_d   = 1'b0;
        end
      end
      ST_CLEAR: begin
        state_d = ST_LOAD_TH;
        cnt_d   = '0;
        rst_d   = 1'b1;
      end
      ST_LOAD_TH, ST_LOAD_DE, ST_LOAD_AM: begin
        if (i_stop) begin
          // abort: wipe the partially filled FIFOs
          state_d = ST_IDLE;
          cnt_d   = '0;
          rst_d   = 1'b1;
        end else if (hs) begin
          if (s_axis_tlast != final_word) begin
            // framing error: swallow the word, do not write it
            state_d = ST_IDLE;
            cnt_d   = '0;
            rst_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            addrs_d = ADDR_W'(field_of(state_q));
            data_d  = s_axis_tdata;
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              case (state_q)
                ST_LOAD_TH: state_d = ST_LOAD_DE;
                ST_LOAD_DE: state_d = ST_LOAD_AM;
                default:    state_d = ST_RUN;
              endcase
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
        if (i_load_req) begin
          state_d = ST_CLEAR;
          err_d   = 1'b0;
        end else if (i_stop) begin
          state_d = ST_IDLE;
        end else begin
          // registered, so start rises only after the last write was presented
          start_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered output stage
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rst_q   <= 1'b0;
      start_q <= 1'b0;
      addrs_q <= IDLE_ADDR;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      start_q <= start_d;
      addrs_q <= addrs_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign s_axis_tready   = loading;
  assign o_busy          = loading || (state_q == ST_CLEAR);
  assign o_dds_rst       = rst_q;
  assign o_dds_start     = start_q;
  assign o_running       = start_q;
  assign o_dds_addrs     = addrs_q;
  assign o_dds_fifo_data = data_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_dds_loader.sv
// Directed bench for dds_loader with a write scoreboard on the dds port.
module tb_dds_loader;
  localparam int SW = 16;
  localparam int NC = 8;
  localparam int AW = 9;
  localparam logic [AW-1:0] IDLE = 9'h1FF;

  logic          clk = 1'b0;
  logic          a_rst_n = 1'b0;
  logic          i_load_req = 1'b0, i_stop = 1'b0;
  logic [SW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
  logic          s_axis_tready, o_dds_rst, o_dds_start, o_busy, o_running, o_err;
  logic [AW-1:0] o_dds_addrs;
  logic [SW-1:0] o_dds_fifo_data;

  typedef struct { logic [AW-1:0] a; logic [SW-1:0] d; } wr_t;
  wr_t exp_q[$];
  int tests = 0, fails = 0, nwr = 0;

  dds_loader #(.SIG_WIDTH(SW), .N_CH(NC), .ADDR_W(AW), .IDLE_ADDR(IDLE)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .i_load_req(i_load_req), .i_stop(i_stop),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .o_dds_rst(o_dds_rst), .o_dds_start(o_dds_start), .o_dds_addrs(o_dds_addrs),
    .o_dds_fifo_data(o_dds_fifo_data), .o_busy(o_busy), .o_running(o_running),
    .o_err(o_err));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one stream beat; the expected dds write is queued when the word should land
  task automatic send_word(input int idx, input logic [SW-1:0] d, input bit last, input bit wr);
    wr_t e;
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = last;
    if (wr) begin
      e.a = AW'(idx / NC); e.d = d;
      exp_q.push_back(e);
    end
    step();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  // load request; returns in the first LOAD_TH cycle
  task automatic start_load();
    i_load_req = 1'b1; step(); i_load_req = 1'b0;
    chk("clear_busy", o_busy, 1); chk("clear_tready", s_axis_tready, 0);
    chk("clear_err_cleared", o_err, 0); chk("clear_rst_early", o_dds_rst, 0);
    step();
    chk("clr_pulse", o_dds_rst, 1); chk("load_tready", s_axis_tready, 1);
  endtask

  task automatic full_frame(input logic [SW-1:0] base, input bit gaps);
    for (int i = 0; i < 3*NC; i++) begin
      send_word(i, base + SW'(i), i == 3*NC-1, 1'b1);
      if (i == 0) chk("clr_single", o_dds_rst, 0);
      if (gaps) begin
        step();
        chk("gap_idle", o_dds_addrs, IDLE);
      end
    end
    if (!gaps) begin
      chk("start_late", o_dds_start, 0);   // cycle 26: last AMPLS write presented
      step();
    end
    chk("start_on", o_dds_start, 1); chk("running", o_running, 1);
    chk("run_busy", o_busy, 0); chk("run_err", o_err, 0);
    chk("run_idle_addr", o_dds_addrs, IDLE);
  endtask

  initial begin
    int n0;
    // scoreboard monitor: every non-idle address cycle is one dds write
    fork
      forever begin
        wr_t e;
        @(negedge clk);
        if (a_rst_n && o_dds_addrs != IDLE) begin
          nwr++;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {23'd0, o_dds_addrs}, {23'd0, IDLE});
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", o_dds_addrs, e.a);
            chk("wr_data", o_dds_fifo_data, e.d);
          end
        end
      end
    join_none

    // 1: reset values, then back-to-back full frame
    repeat (3) step();
    chk("rst_tready", s_axis_tready, 0); chk("rst_dds_rst", o_dds_rst, 0);
    chk("rst_start", o_dds_start, 0); chk("rst_addr", o_dds_addrs, IDLE);
    chk("rst_data", o_dds_fifo_data, 0); chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    a_rst_n = 1'b1; step();
    chk("idle_busy", o_busy, 0);
    start_load();
    full_frame(16'h1000, 1'b0);

    // 2: tvalid toggling, reload straight from RUN
    n0 = nwr;
    start_load();
    full_frame(16'h2000, 1'b1);
    chk("gap_write_count", nwr - n0, 3*NC);

    // 3: early tlast on word 10
    step();
    start_load();
    for (int i = 0; i < 10; i++) send_word(i, 16'h3000 + SW'(i), i == 9, i != 9);
    chk("early_err", o_err, 1); chk("early_rst", o_dds_rst, 1);
    chk("early_tready", s_axis_tready, 0); chk("early_busy", o_busy, 0);
    chk("early_noaddr", o_dds_addrs, IDLE);
    step();
    chk("early_rst_single", o_dds_rst, 0); chk("early_err_sticky", o_err, 1);

    // 4: missing tlast on word 24 (start_load also checks err clears)
    start_load();
    for (int i = 0; i < 3*NC; i++) send_word(i, 16'h4000 + SW'(i), 1'b0, i != 3*NC-1);
    chk("notlast_err", o_err, 1); chk("notlast_rst", o_dds_rst, 1);
    repeat (3) step();
    chk("notlast_nostart", o_dds_start, 0);

    // 5: abort mid-load, stop in RUN, load+stop in RUN
    start_load();
    for (int i = 0; i < 5; i++) send_word(i, 16'h5000 + SW'(i), 1'b0, 1'b1);
    i_stop = 1'b1; step(); i_stop = 1'b0;
    chk("abort_rst", o_dds_rst, 1); chk("abort_busy", o_busy, 0);
    chk("abort_tready", s_axis_tready, 0); chk("abort_err", o_err, 0);
    start_load();
    full_frame(16'h6000, 1'b0);
    i_stop = 1'b1; step(); i_stop = 1'b0;
    chk("stop_start", o_dds_start, 0); chk("stop_running", o_running, 0);
    chk("stop_norst", o_dds_rst, 0);
    step();
    chk("stop_norst2", o_dds_rst, 0); chk("stop_idle", o_busy, 0);
    start_load();
    full_frame(16'h7000, 1'b0);
    i_load_req = 1'b1; i_stop = 1'b1; step(); i_load_req = 1'b0; i_stop = 1'b0;
    chk("both_clear", o_busy, 1); chk("both_start", o_dds_start, 0);
    step();
    chk("both_rst", o_dds_rst, 1);

    // 6: async reset in LOAD_DE, then a fresh full load
    for (int i = 0; i < NC + 3; i++) send_word(i, 16'h8000 + SW'(i), 1'b0, 1'b1);
    step();
    chk("pre_rst_busy", o_busy, 1);
    #3 a_rst_n = 1'b0;
    #1;
    chk("arst_tready", s_axis_tready, 0); chk("arst_addr", o_dds_addrs, IDLE);
    chk("arst_data", o_dds_fifo_data, 0); chk("arst_busy", o_busy, 0);
    chk("arst_start", o_dds_start, 0); chk("arst_rst", o_dds_rst, 0);
    step(); a_rst_n = 1'b1; step();
    start_load();
    full_frame(16'h9000, 1'b0);
    repeat (2) step();
    chk("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
